// File: rtl/divby3_word_feeder.sv
// Word-to-serial feeder for the divisible-by-3 FSM: clears it, shifts a word MSB first, returns the flag.
// Optional DIVBY3_SELFCHK_EN adds chk_err, a shadow remainder cross-check of the downstream flag.
module divby3_word_feeder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_bit,
    output logic         fsm_rstn,
    input  logic         div_in,
    output logic         res_valid,
    output logic         res_div,
`ifdef DIVBY3_SELFCHK_EN
    output logic [W-1:0] res_data,
    output logic         chk_err
`else
    output logic [W-1:0] res_data
`endif
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLR    = 2'd1,
        SHIFT  = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           ser_bit_q, ser_bit_d;
    logic           fsm_rstn_q, fsm_rstn_d;
    logic           res_valid_q, res_valid_d;
    logic           res_div_q, res_div_d;
    logic [W-1:0]   res_data_q, res_data_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        ser_bit_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shreg_d = in_data;
                    hold_d  = in_data;
                    state_d = CLR;
                end
            end
            CLR: begin
                state_d   = SHIFT;
                cnt_d     = CW'(W - 1);
                ser_bit_d = shreg_q[W-1];
                shreg_d   = shreg_q << 1;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    ser_bit_d = shreg_q[W-1];
                    shreg_d   = shreg_q << 1;
                end
            end
            SAMPLE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded from the next state so every output is a clean register.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        fsm_rstn_d  = (state_d != CLR);
        res_valid_d = (state_q == SAMPLE);
        res_div_d   = res_div_q;
        res_data_d  = res_data_q;
        if (state_q == SAMPLE) begin
            res_div_d  = div_in;
            res_data_d = hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            ser_bit_q   <= 1'b0;
            fsm_rstn_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_div_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            ser_bit_q   <= ser_bit_d;
            fsm_rstn_q  <= fsm_rstn_d;
            res_valid_q <= res_valid_d;
            res_div_q   <= res_div_d;
            res_data_q  <= res_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign ser_bit   = ser_bit_q;
    assign fsm_rstn  = fsm_rstn_q;
    assign res_valid = res_valid_q;
    assign res_div   = res_div_q;
    assign res_data  = res_data_q;

`ifdef DIVBY3_SELFCHK_EN
    logic [1:0] rem_q, rem_d;
    logic       chk_err_q, chk_err_d;

    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        unique case ({r, b})
            3'b000:  n = 2'd0;
            3'b001:  n = 2'd1;
            3'b010:  n = 2'd2;
            3'b011:  n = 2'd0;
            3'b100:  n = 2'd1;
            3'b101:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // ser_bit_q is the bit the downstream FSM consumes at this edge.
    always_comb begin
        rem_d     = rem_q;
        chk_err_d = 1'b0;
        unique case (state_q)
            CLR:     rem_d = 2'd0;
            SHIFT:   rem_d = mod3_step(rem_q, ser_bit_q);
            SAMPLE:  chk_err_d = (div_in != (rem_q == 2'd0));
            default: rem_d = rem_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= 2'd0;
            chk_err_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule
